// File: rtl/k_means_apb_master.sv
// -----------------------------------------------------------------------------
// k_means_apb_master
//
// Single-outstanding APB requester. A command presented on the cmd_* handshake
// is turned into one APB transfer (SETUP for one cycle, then ACCESS until the
// completer raises pready). Completion is reported with a one-cycle rsp_valid
// pulse carrying the read data (zero for writes). Every output is registered.
//
// Optional feature (macro K_MEANS_APB_TIMEOUT_EN): bounds the number of
// ACCESS cycles with pready low to TIMEOUT_CYCLES; on expiry the transfer is
// abandoned and rsp_valid is pulsed with rsp_timeout=1 and rsp_rdata=0.
// Without the macro the transfer waits indefinitely and rsp_timeout is tied 0.
//
// Ports
//   clk, rst          : rising-edge clock, asynchronous active-high reset
//   cmd_valid/ready   : command handshake (ready only while idle)
//   cmd_write         : 1 = write, 0 = read
//   cmd_addr/wdata    : target address / write data
//   rsp_valid         : one-cycle completion pulse
//   rsp_rdata         : read data (held until the next completion)
//   rsp_timeout       : completion was a timeout abort
//   busy              : a transfer is in progress
//   paddr..pwdata     : APB requester outputs
//   prdata, pready    : APB completer inputs
// -----------------------------------------------------------------------------
module k_means_apb_master #(
    parameter int addrWidth      = 8,
    parameter int dataWidth      = 91,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_write,
    input  logic [addrWidth-1:0] cmd_addr,
    input  logic [dataWidth-1:0] cmd_wdata,
    output logic                 rsp_valid,
    output logic [dataWidth-1:0] rsp_rdata,
    output logic                 rsp_timeout,
    output logic                 busy,
    output logic [addrWidth-1:0] paddr,
    output logic                 pwrite,
    output logic                 psel,
    output logic                 penable,
    output logic [dataWidth-1:0] pwdata,
    input  logic [dataWidth-1:0] prdata,
    input  logic                 pready
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_next_state;
    logic                 w_accept;
    logic                 w_done;
    logic                 w_abort;
    logic                 w_expire;

    logic                 r_cmd_ready;
    logic                 r_busy;
    logic                 r_psel;
    logic                 r_penable;
    logic                 r_pwrite;
    logic                 r_rsp_valid;
    logic [addrWidth-1:0] r_paddr;
    logic [dataWidth-1:0] r_pwdata;
    logic [dataWidth-1:0] r_rsp_rdata;

    generate
        if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
            $error("TIMEOUT_CYCLES must be at least 1");
        end
    endgenerate

`ifdef K_MEANS_APB_TIMEOUT_EN
    localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_wait_cnt;
    logic             r_rsp_timeout;

    // Counter holds the number of already-elapsed pready-low ACCESS cycles,
    // so the current cycle is the last allowed one when it equals CNT_LAST.
    assign w_expire = (r_wait_cnt == CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wait_cnt <= '0;
        end else if (r_state == SETUP) begin
            r_wait_cnt <= '0;
        end else if (r_state == ACCESS && !pready) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rsp_timeout <= 1'b0;
        end else begin
            r_rsp_timeout <= w_abort;
        end
    end

    assign rsp_timeout = r_rsp_timeout;
`else
    assign w_expire    = 1'b0;
    assign rsp_timeout = 1'b0;
`endif

    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_done       = 1'b0;
        w_abort      = 1'b0;
        case (r_state)
            IDLE: begin
                if (cmd_valid) begin
                    w_accept     = 1'b1;
                    w_next_state = SETUP;
                end
            end
            SETUP: begin
                w_next_state = ACCESS;
            end
            ACCESS: begin
                // pready wins over an expiring counter on the same edge
                if (pready) begin
                    w_done       = 1'b1;
                    w_next_state = IDLE;
                end else if (w_expire) begin
                    w_abort      = 1'b1;
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cmd_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_pwrite    <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_paddr     <= '0;
            r_pwdata    <= '0;
            r_rsp_rdata <= '0;
        end else begin
            r_state     <= w_next_state;
            // Control outputs are decoded from the next state so they line
            // up with the state register rather than lagging a cycle.
            r_cmd_ready <= (w_next_state == IDLE);
            r_busy      <= (w_next_state != IDLE);
            r_psel      <= (w_next_state != IDLE);
            r_penable   <= (w_next_state == ACCESS);
            r_rsp_valid <= w_done | w_abort;
            if (w_accept) begin
                r_paddr  <= cmd_addr;
                r_pwrite <= cmd_write;
                r_pwdata <= cmd_write ? cmd_wdata : '0;
            end
            if (w_done) begin
                r_rsp_rdata <= r_pwrite ? '0 : prdata;
            end else if (w_abort) begin
                r_rsp_rdata <= '0;
            end
        end
    end

    assign cmd_ready = r_cmd_ready;
    assign busy      = r_busy;
    assign psel      = r_psel;
    assign penable   = r_penable;
    assign pwrite    = r_pwrite;
    assign paddr     = r_paddr;
    assign pwdata    = r_pwdata;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;

endmodule

// File: tb/tb_k_means_apb_master.sv
// -----------------------------------------------------------------------------
// tb_k_means_apb_master
//
// Directed transfers (write, read with wait states, back-to-back, reset
// during ACCESS and, when K_MEANS_APB_TIMEOUT_EN is defined, a timeout) with
// hand-computed expectations, followed by randomized traffic. A transaction-
// level model tracks every accepted command and predicts the outputs, which
// are compared each cycle shortly after the rising edge.
// -----------------------------------------------------------------------------
module tb_k_means_apb_master;

    localparam int AW = 8;
    localparam int DW = 91;
`ifdef K_MEANS_APB_TIMEOUT_EN
    localparam int TO    = 4;
    localparam bit TO_EN = 1'b1;
`else
    localparam int TO    = 256;
    localparam bit TO_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_timeout;
    logic          busy;
    logic [AW-1:0] paddr;
    logic          pwrite;
    logic          psel;
    logic          penable;
    logic [DW-1:0] pwdata;
    logic [DW-1:0] prdata;
    logic          pready;

    int pass_cnt = 0;
    int tot_cnt  = 0;

    k_means_apb_master #(
        .addrWidth     (AW),
        .dataWidth     (DW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_write  (cmd_write),
        .cmd_addr   (cmd_addr),
        .cmd_wdata  (cmd_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_timeout(rsp_timeout),
        .busy       (busy),
        .paddr      (paddr),
        .pwrite     (pwrite),
        .psel       (psel),
        .penable    (penable),
        .pwdata     (pwdata),
        .prdata     (prdata),
        .pready     (pready)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        tot_cnt++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end else begin
            pass_cnt++;
        end
    endtask

    function automatic logic [DW-1:0] rnd_data();
        logic [95:0] t;
        t = {$urandom, $urandom, $urandom};
        return t[DW-1:0];
    endfunction

    // ------------------------------------------------------------------
    // Transaction-level model: one outstanding command, aged in cycles
    // since acceptance (age 1 = SETUP cycle, age >= 2 = ACCESS cycles).
    // ------------------------------------------------------------------
    bit            m_active;
    int            m_age;
    bit            m_rsp_v;
    bit            m_rsp_to;
    logic [DW-1:0] m_rdata;
    logic [AW-1:0] m_addr;
    bit            m_wr;
    logic [DW-1:0] m_wdata;

    always @(posedge clk) begin
        if (rst) begin
            m_active = 1'b0;
            m_age    = 0;
            m_rsp_v  = 1'b0;
            m_rsp_to = 1'b0;
            m_rdata  = '0;
            m_addr   = '0;
            m_wr     = 1'b0;
            m_wdata  = '0;
        end else begin
            m_rsp_v  = 1'b0;
            m_rsp_to = 1'b0;
            if (m_active) begin
                if (m_age >= 2 && pready) begin
                    m_active = 1'b0;
                    m_rsp_v  = 1'b1;
                    m_rdata  = m_wr ? '0 : prdata;
                end else if (TO_EN && m_age >= 2 && (m_age - 1) == TO) begin
                    m_active = 1'b0;
                    m_rsp_v  = 1'b1;
                    m_rsp_to = 1'b1;
                    m_rdata  = '0;
                end else begin
                    m_age++;
                end
            end else if (cmd_valid) begin
                m_active = 1'b1;
                m_age    = 1;
                m_addr   = cmd_addr;
                m_wr     = cmd_write;
                m_wdata  = cmd_write ? cmd_wdata : '0;
            end
        end
        #1;
        check("rsp_valid",   rsp_valid,   m_rsp_v);
        check("rsp_timeout", rsp_timeout, m_rsp_to);
        check("rsp_rdata",   rsp_rdata,   m_rdata);
        check("cmd_ready",   cmd_ready,   !m_active);
        check("busy",        busy,        m_active);
        check("psel",        psel,        m_active);
        check("penable",     penable,     m_active && m_age >= 2);
        if (m_active) begin
            check("paddr",  paddr,  m_addr);
            check("pwrite", pwrite, m_wr);
            check("pwdata", pwdata, m_wdata);
        end
    end

    // ------------------------------------------------------------------
    // Directed transfer: waits = number of pready-low ACCESS cycles before
    // pready goes high (-1 = never).
    // ------------------------------------------------------------------
    task automatic do_cmd(input string nm, input bit wr, input logic [AW-1:0] a,
                          input logic [DW-1:0] wd, input int waits, input logic [DW-1:0] rd,
                          input logic [DW-1:0] exp_rd, input bit exp_to, input int exp_acc);
        int acc;
        bit seen;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_wdata = wd;
        pready    = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_wdata = rnd_data();
        check({nm, "_setup"}, {psel, penable}, 2'b10);
        check({nm, "_paddr"}, paddr, a);
        check({nm, "_pwdata"}, pwdata, wr ? wd : '0);
        acc  = 0;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (penable) begin
                acc++;
                pready = (acc == waits + 1);
                prdata = (acc == waits + 1) ? rd : rnd_data();
            end else begin
                pready = 1'($urandom % 2);
                prdata = rnd_data();
            end
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        pready = 1'b0;
        check({nm, "_done"},    seen,        1'b1);
        check({nm, "_acc_len"}, acc,         exp_acc);
        check({nm, "_rdata"},   rsp_rdata,   exp_rd);
        check({nm, "_timeout"}, rsp_timeout, exp_to);
        check({nm, "_idle"},    {psel, penable, busy, cmd_ready}, 4'b0001);
        @(negedge clk);
        check({nm, "_pulse"}, rsp_valid, 1'b0);
        check({nm, "_hold"},  rsp_rdata, exp_rd);
    endtask

    task automatic do_b2b();
        int  t;
        int  n_acc;
        int  rise1;
        int  rise2;
        bit  prev;
        bit  was_rdy;
        bit  rsp_at_accept;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 8'h40;
        cmd_wdata = 91'h111;
        pready    = 1'b1;
        t = 0; n_acc = 0; rise1 = -1; rise2 = -1;
        prev = psel;
        rsp_at_accept = 1'b0;
        was_rdy = cmd_valid && cmd_ready;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            t++;
            prdata = rnd_data();
            if (was_rdy) begin
                n_acc++;
                if (n_acc == 1) begin
                    cmd_write = 1'b0;
                    cmd_addr  = 8'h44;
                    cmd_wdata = 91'h222;
                end else begin
                    cmd_valid = 1'b0;
                end
            end
            if (psel && !prev) begin
                if (rise1 < 0) rise1 = t;
                else if (rise2 < 0) rise2 = t;
            end
            if (n_acc == 1 && cmd_ready && cmd_valid) rsp_at_accept = rsp_valid;
            prev    = psel;
            was_rdy = cmd_valid && cmd_ready;
        end
        pready = 1'b0;
        check("b2b_accepts",      n_acc,         2);
        check("b2b_rsp_at_acc",   rsp_at_accept, 1'b1);
        check("b2b_rise_spacing", rise2 - rise1, 3);
    endtask

    task automatic do_reset_mid_access();
        bit got;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 8'h33;
        pready    = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (penable) got = 1'b1;
        end
        check("rst_reach_access", got, 1'b1);
        #2 rst = 1'b1;
        #1 check("rst_async", {psel, penable, busy, rsp_valid}, 4'b0000);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_no_rsp", rsp_valid, 1'b0);
        end
        do_cmd("after_rst", 1'b1, 8'h07, 91'h99, 1, '0, '0, 1'b0, 2);
    endtask

    task automatic do_random(input int n);
        bit was_rdy;
        was_rdy = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (was_rdy || !cmd_valid) begin
                cmd_valid = ($urandom % 3) != 0;
                cmd_write = 1'($urandom % 2);
                cmd_addr  = AW'($urandom);
                cmd_wdata = rnd_data();
            end
            pready  = ($urandom % 3) == 0;
            prdata  = rnd_data();
            was_rdy = cmd_valid && cmd_ready;
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        pready    = 1'b1;
        repeat (6) @(negedge clk);
        pready = 1'b0;
        check("rand_drained", {busy, cmd_ready}, 2'b01);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        prdata    = '0;
        pready    = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_ready", {cmd_ready, busy, psel, penable, pwrite, rsp_valid}, 6'b100000);
        check("reset_paddr", paddr, '0);
        check("reset_pwdata", pwdata, '0);
        check("reset_rdata", rsp_rdata, '0);

        do_cmd("wr_fast", 1'b1, 8'h04, 91'h5, 0, 91'h777, '0, 1'b0, 1);
        do_cmd("rd_wait3", 1'b0, 8'h10, 91'habc, 3, 91'h1234, 91'h1234, 1'b0, 4);
`ifdef K_MEANS_APB_TIMEOUT_EN
        do_cmd("rd_timeout", 1'b0, 8'h20, 91'h0, -1, 91'h55, '0, 1'b1, 4);
        do_cmd("wr_wait2", 1'b1, 8'h24, 91'h3c, 2, 91'h9, '0, 1'b0, 3);
`endif
        do_b2b();
        do_reset_mid_access();
        do_random(3000);

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
